// File: rtl/weight_dispatcher.sv
// Streams len ROM words starting at base_addr into NUM_NODES node FIFOs, either
// round-robin (one node per word) or broadcast (every node per word), one fetch per cycle.
module weight_dispatcher #(
  parameter int NUM_NODES   = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [NUM_NODES-1:0]  node_full_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [NUM_NODES-1:0]  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  all_done_o
);

  localparam int PTR_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    mode_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic [ADDR_WIDTH:0]     issued_q;
  logic [PTR_W-1:0]        ptr_q;
  logic                    rom_en_q;
  logic [ADDR_WIDTH-1:0]   rom_addr_q;
  logic [NUM_NODES-1:0]    wr_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    all_done_q;

  // Stage 0 is loaded together with rom_en; stage ROM_LATENCY lines up with valid rom_data.
  logic [ROM_LATENCY:0]    pipe_vld_q;
  logic [NUM_NODES-1:0]    pipe_mask_q [ROM_LATENCY+1];

  logic                    accept;
  logic                    issue;
  logic                    node_ready;
  logic [NUM_NODES-1:0]    issue_mask;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue      = 1'b0;
    issue_mask = '0;
    node_ready = mode_q ? (node_full_i == '0) : ~node_full_i[ptr_q];
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (len_i == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else if (node_ready) begin
          issue      = 1'b1;
          issue_mask = mode_q ? {NUM_NODES{1'b1}} : (NUM_NODES'(1) << ptr_q);
        end
      end
      S_DRAIN: begin
        if (pipe_vld_q == '0) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      all_done_q <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) pipe_mask_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rom_en_q <= issue;
      if (accept) begin
        mode_q   <= mode_i;
        base_q   <= base_addr_i;
        len_q    <= len_i;
        issued_q <= '0;
        ptr_q    <= '0;
      end
      if (issue) begin
        rom_addr_q <= base_q + issued_q[ADDR_WIDTH-1:0];
        issued_q   <= issued_q + 1'b1;
        if (!mode_q) ptr_q <= (ptr_q == PTR_W'(NUM_NODES - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
      pipe_vld_q     <= {pipe_vld_q[ROM_LATENCY-1:0], issue};
      pipe_mask_q[0] <= issue_mask;
      for (int i = 1; i <= ROM_LATENCY; i++) pipe_mask_q[i] <= pipe_mask_q[i-1];
      // FIFO writes are never throttled here; node_full headroom covers in-flight words.
      wr_en_q <= pipe_vld_q[ROM_LATENCY] ? pipe_mask_q[ROM_LATENCY] : '0;
      if (pipe_vld_q[ROM_LATENCY]) wr_data_q <= rom_data_i;
      if (state_d == S_FINISH) all_done_q <= 1'b1;
      else if (accept)         all_done_q <= 1'b0;
    end
  end

  assign rom_en_o   = rom_en_q;
  assign rom_addr_o = rom_addr_q;
  assign wr_en_o    = wr_en_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_FINISH);
  assign all_done_o = all_done_q;

endmodule

// File: tb/tb_weight_dispatcher.sv
// Directed bench for weight_dispatcher: a 1-cycle-ROM instance and a 3-cycle-ROM instance,
// each fed by a behavioural ROM whose content is a fixed function of the address.
module tb_weight_dispatcher;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, start_b = 1'b0, mode = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [N-1:0]  node_full = '0;

  logic          rom_en_a, busy_a, done_a, all_done_a;
  logic [AW-1:0] rom_addr_a;
  logic [DW-1:0] rom_data_a, wr_data_a;
  logic [N-1:0]  wr_en_a;
  logic          rom_en_b, busy_b, done_b, all_done_b;
  logic [AW-1:0] rom_addr_b;
  logic [DW-1:0] rom_data_b, wr_data_b;
  logic [N-1:0]  wr_en_b;

  int checks = 0, fails = 0, cyc = 0;
  int ra_cyc[$], ra_addr[$], wa_cyc[$], wa_mask[$], wa_data[$];
  int rb_cyc[$], rb_addr[$], wb_cyc[$], wb_mask[$], wb_data[$];
  int da_cnt = 0, da_cyc = 0, db_cnt = 0, db_cyc = 0;

  weight_dispatcher #(.NUM_NODES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .mode_i(mode), .base_addr_i(base),
    .len_i(len), .node_full_i(node_full), .rom_en_o(rom_en_a), .rom_addr_o(rom_addr_a),
    .rom_data_i(rom_data_a), .wr_en_o(wr_en_a), .wr_data_o(wr_data_a), .busy_o(busy_a),
    .done_o(done_a), .all_done_o(all_done_a));

  weight_dispatcher #(.NUM_NODES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .mode_i(mode), .base_addr_i(base),
    .len_i(len), .node_full_i(node_full), .rom_en_o(rom_en_b), .rom_addr_o(rom_addr_b),
    .rom_data_i(rom_data_b), .wr_en_o(wr_en_b), .wr_data_o(wr_data_b), .busy_o(busy_b),
    .done_o(done_b), .all_done_o(all_done_b));

  function automatic logic [15:0] rom_val(input int a);
    return 16'(a * 37 + 4660);
  endfunction

  logic [DW-1:0] rom_q_a, b_s1, b_s2, b_s3;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rom_q_a <= rom_en_a ? rom_val(int'(rom_addr_a)) : 16'hDEAD;
    b_s1    <= rom_en_b ? rom_val(int'(rom_addr_b)) : 16'hDEAD;
    b_s2    <= b_s1;
    b_s3    <= b_s2;
  end
  assign rom_data_a = rom_q_a;
  assign rom_data_b = b_s3;

  always @(negedge clk) begin
    if (rom_en_a) begin ra_cyc.push_back(cyc); ra_addr.push_back(int'(rom_addr_a)); end
    if (wr_en_a != '0) begin
      wa_cyc.push_back(cyc); wa_mask.push_back(int'(wr_en_a)); wa_data.push_back(int'(wr_data_a));
    end
    if (done_a) begin da_cnt++; da_cyc = cyc; end
    if (rom_en_b) begin rb_cyc.push_back(cyc); rb_addr.push_back(int'(rom_addr_b)); end
    if (wr_en_b != '0) begin
      wb_cyc.push_back(cyc); wb_mask.push_back(int'(wr_en_b)); wb_data.push_back(int'(wr_data_b));
    end
    if (done_b) begin db_cnt++; db_cyc = cyc; end
  end

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (done_a) ok = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({rom_en_a, busy_a, done_a, all_done_a} !== 4'b0) begin fails++;
      $display("FAIL reset_flags: got %b expected 0000", {rom_en_a, busy_a, done_a, all_done_a}); end
    checks++; if (rom_addr_a !== '0) begin fails++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr_a); end
    checks++; if (wr_en_a !== '0) begin fails++; $display("FAIL reset_wr_en: got %b expected 0000", wr_en_a); end
    checks++; if (wr_data_a !== '0) begin fails++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data_a); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({rom_en_a, busy_a, wr_en_a} !== 6'b0) begin fails++;
      $display("FAIL reset_idle_after_release: got %b expected 000000", {rom_en_a, busy_a, wr_en_a}); end
  endtask

  task automatic test_rr_basic();
    int r0, w0, d0; bit ok;
    r0 = ra_addr.size(); w0 = wa_mask.size(); d0 = da_cnt;
    mode = 1'b0; base = 8'd0; len = 9'd8; node_full = '0;
    pulse_start_a();
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL rr_busy_high: got %b expected 1", busy_a); end
    wait_done_a(60, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rr_done_timeout: got no done expected done"); end
    checks++; if (ra_addr.size() - r0 != 8) begin fails++; $display("FAIL rr_fetch_count: got %0d expected 8", ra_addr.size() - r0); end
    checks++; if (wa_mask.size() - w0 != 8) begin fails++; $display("FAIL rr_write_count: got %0d expected 8", wa_mask.size() - w0); end
    for (int i = 0; i < 8; i++) if (r0 + i < ra_addr.size() && w0 + i < wa_mask.size()) begin
      checks++; if (ra_addr[r0+i] != i) begin fails++; $display("FAIL rr_addr[%0d]: got %0d expected %0d", i, ra_addr[r0+i], i); end
      checks++; if (ra_cyc[r0+i] != ra_cyc[r0] + i) begin fails++; $display("FAIL rr_full_rate[%0d]: got cycle %0d expected %0d", i, ra_cyc[r0+i], ra_cyc[r0] + i); end
      checks++; if (wa_mask[w0+i] != (1 << (i % 4))) begin fails++; $display("FAIL rr_mask[%0d]: got %0h expected %0h", i, wa_mask[w0+i], 1 << (i % 4)); end
      checks++; if (wa_data[w0+i] != int'(rom_val(i))) begin fails++; $display("FAIL rr_data[%0d]: got %0h expected %0h", i, wa_data[w0+i], rom_val(i)); end
      checks++; if (wa_cyc[w0+i] - ra_cyc[r0+i] != 2) begin fails++; $display("FAIL rr_latency[%0d]: got %0d expected 2", i, wa_cyc[w0+i] - ra_cyc[r0+i]); end
    end
    checks++; if (da_cnt - d0 != 1) begin fails++; $display("FAIL rr_done_pulses: got %0d expected 1", da_cnt - d0); end
    if (w0 + 7 < wa_cyc.size()) begin
      checks++; if (da_cyc != wa_cyc[w0+7] + 1) begin fails++; $display("FAIL rr_done_timing: got cycle %0d expected %0d", da_cyc, wa_cyc[w0+7] + 1); end
    end
    checks++; if ({busy_a, all_done_a} !== 2'b01) begin fails++; $display("FAIL rr_end_flags: got busy,all_done=%b expected 01", {busy_a, all_done_a}); end
  endtask

  task automatic test_rr_stall();
    int r0, w0; bit ok;
    r0 = ra_addr.size(); w0 = wa_mask.size();
    mode = 1'b0; base = 8'h20; len = 9'd8; node_full = 4'b0100;
    pulse_start_a();
    repeat (4) @(negedge clk);
    checks++; if (rom_en_a !== 1'b0 || rom_addr_a !== 8'h21) begin fails++;
      $display("FAIL stall_hold: got en=%b addr=%0h expected en=0 addr=21", rom_en_a, rom_addr_a); end
    repeat (3) @(negedge clk);
    node_full = '0;
    wait_done_a(80, ok);
    checks++; if (!ok) begin fails++; $display("FAIL stall_done_timeout: got no done expected done"); end
    checks++; if (ra_addr.size() - r0 != 8) begin fails++; $display("FAIL stall_fetch_count: got %0d expected 8", ra_addr.size() - r0); end
    if (r0 + 2 < ra_cyc.size()) begin
      checks++; if (ra_cyc[r0+2] - ra_cyc[r0+1] != 6) begin fails++; $display("FAIL stall_gap: got %0d expected 6", ra_cyc[r0+2] - ra_cyc[r0+1]); end
    end
    for (int i = 0; i < 8; i++) if (r0 + i < ra_addr.size() && w0 + i < wa_mask.size()) begin
      checks++; if (ra_addr[r0+i] != 32 + i) begin fails++; $display("FAIL stall_addr[%0d]: got %0h expected %0h", i, ra_addr[r0+i], 32 + i); end
      checks++; if (wa_mask[w0+i] != (1 << (i % 4))) begin fails++; $display("FAIL stall_mask[%0d]: got %0h expected %0h", i, wa_mask[w0+i], 1 << (i % 4)); end
      checks++; if (wa_data[w0+i] != int'(rom_val(32 + i))) begin fails++; $display("FAIL stall_data[%0d]: got %0h expected %0h", i, wa_data[w0+i], rom_val(32 + i)); end
    end
  endtask

  task automatic test_broadcast();
    int r0, w0; bit ok;
    r0 = ra_addr.size(); w0 = wa_mask.size();
    mode = 1'b1; base = 8'd10; len = 9'd3; node_full = 4'b1000;
    pulse_start_a();
    repeat (4) @(negedge clk);
    checks++; if (ra_addr.size() - r0 != 0) begin fails++; $display("FAIL bc_stall_any_bit: got %0d fetches expected 0", ra_addr.size() - r0); end
    node_full = '0;
    wait_done_a(40, ok);
    checks++; if (!ok) begin fails++; $display("FAIL bc_done_timeout: got no done expected done"); end
    checks++; if (wa_mask.size() - w0 != 3) begin fails++; $display("FAIL bc_write_count: got %0d expected 3", wa_mask.size() - w0); end
    for (int i = 0; i < 3; i++) if (r0 + i < ra_addr.size() && w0 + i < wa_mask.size()) begin
      checks++; if (ra_addr[r0+i] != 10 + i) begin fails++; $display("FAIL bc_addr[%0d]: got %0d expected %0d", i, ra_addr[r0+i], 10 + i); end
      checks++; if (wa_mask[w0+i] != 15) begin fails++; $display("FAIL bc_mask[%0d]: got %0h expected f", i, wa_mask[w0+i]); end
      checks++; if (wa_data[w0+i] != int'(rom_val(10 + i))) begin fails++; $display("FAIL bc_data[%0d]: got %0h expected %0h", i, wa_data[w0+i], rom_val(10 + i)); end
    end
  endtask

  task automatic test_len_zero();
    int r0, w0;
    r0 = ra_addr.size(); w0 = wa_mask.size();
    mode = 1'b0; base = 8'd5; len = 9'd0;
    pulse_start_a();
    checks++; if ({done_a, all_done_a} !== 2'b11) begin fails++; $display("FAIL len0_done: got done,all_done=%b expected 11", {done_a, all_done_a}); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0) begin fails++; $display("FAIL len0_done_width: got %b expected 0", done_a); end
    repeat (4) @(negedge clk);
    checks++; if (ra_addr.size() - r0 + wa_mask.size() - w0 != 0) begin fails++;
      $display("FAIL len0_no_traffic: got %0d events expected 0", ra_addr.size() - r0 + wa_mask.size() - w0); end
    checks++; if (all_done_a !== 1'b1) begin fails++; $display("FAIL len0_all_done_level: got %b expected 1", all_done_a); end
  endtask

  task automatic test_wrap_and_ignore();
    int r0, w0, d0; bit ok;
    r0 = ra_addr.size(); w0 = wa_mask.size(); d0 = da_cnt;
    mode = 1'b0; base = 8'd254; len = 9'd4;
    pulse_start_a();
    checks++; if ({busy_a, all_done_a} !== 2'b10) begin fails++; $display("FAIL wrap_accept_flags: got busy,all_done=%b expected 10", {busy_a, all_done_a}); end
    @(negedge clk); start_a = 1'b1; mode = 1'b1; base = 8'h55; len = 9'd1;
    @(negedge clk); start_a = 1'b0;
    wait_done_a(40, ok);
    repeat (6) @(negedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL wrap_done_timeout: got no done expected done"); end
    checks++; if (ra_addr.size() - r0 != 4) begin fails++; $display("FAIL wrap_fetch_count: got %0d expected 4", ra_addr.size() - r0); end
    checks++; if (da_cnt - d0 != 1) begin fails++; $display("FAIL wrap_done_pulses: got %0d expected 1", da_cnt - d0); end
    for (int i = 0; i < 4; i++) if (r0 + i < ra_addr.size() && w0 + i < wa_mask.size()) begin
      checks++; if (ra_addr[r0+i] != (254 + i) % 256) begin fails++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, ra_addr[r0+i], (254 + i) % 256); end
      checks++; if (wa_mask[w0+i] != (1 << i)) begin fails++; $display("FAIL wrap_mask[%0d]: got %0h expected %0h", i, wa_mask[w0+i], 1 << i); end
      checks++; if (wa_data[w0+i] != int'(rom_val((254 + i) % 256))) begin fails++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", i, wa_data[w0+i], rom_val((254 + i) % 256)); end
    end
  endtask

  task automatic test_reset_midrun();
    int r0, w0, r1, w1; bit ok;
    w0 = wa_mask.size();
    mode = 1'b0; base = 8'd0; len = 9'd8; node_full = '0;
    pulse_start_a();
    for (int n = 0; n < 40 && wa_mask.size() - w0 < 3; n++) @(negedge clk);
    checks++; if (wa_mask.size() - w0 != 3) begin fails++; $display("FAIL midrst_pre_writes: got %0d expected 3", wa_mask.size() - w0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rom_en_a, busy_a, done_a, all_done_a, wr_en_a} !== 8'b0 || rom_addr_a !== '0 || wr_data_a !== '0) begin fails++;
      $display("FAIL midrst_async_clear: got en=%b busy=%b wr_en=%b addr=%0h data=%0h expected all 0", rom_en_a, busy_a, wr_en_a, rom_addr_a, wr_data_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r1 = ra_addr.size(); w1 = wa_mask.size();
    repeat (10) @(negedge clk);
    checks++; if (ra_addr.size() - r1 + wa_mask.size() - w1 != 0) begin fails++;
      $display("FAIL midrst_no_stale_writes: got %0d events expected 0", ra_addr.size() - r1 + wa_mask.size() - w1); end
    r0 = ra_addr.size(); w0 = wa_mask.size();
    base = 8'h40; len = 9'd4;
    pulse_start_a();
    wait_done_a(40, ok);
    checks++; if (!ok || wa_mask.size() - w0 != 4) begin fails++; $display("FAIL midrst_restart_count: got %0d writes expected 4", wa_mask.size() - w0); end
    if (r0 < ra_addr.size() && w0 < wa_mask.size()) begin
      checks++; if (ra_addr[r0] != 64) begin fails++; $display("FAIL midrst_restart_addr: got %0h expected 40", ra_addr[r0]); end
      checks++; if (wa_mask[w0] != 1) begin fails++; $display("FAIL midrst_restart_node: got %0h expected 1", wa_mask[w0]); end
      checks++; if (wa_data[w0] != int'(rom_val(64))) begin fails++; $display("FAIL midrst_restart_data: got %0h expected %0h", wa_data[w0], rom_val(64)); end
    end
  endtask

  task automatic test_latency3();
    int r0, w0, d0; bit got;
    r0 = rb_addr.size(); w0 = wb_mask.size(); d0 = db_cnt;
    mode = 1'b0; base = 8'd0; len = 9'd8; node_full = '0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin @(negedge clk); if (done_b) got = 1'b1; end
    @(negedge clk);
    checks++; if (!got) begin fails++; $display("FAIL l3_done_timeout: got no done expected done"); end
    checks++; if (wb_mask.size() - w0 != 8) begin fails++; $display("FAIL l3_write_count: got %0d expected 8", wb_mask.size() - w0); end
    for (int i = 0; i < 8; i++) if (r0 + i < rb_addr.size() && w0 + i < wb_mask.size()) begin
      checks++; if (rb_addr[r0+i] != i || rb_cyc[r0+i] != rb_cyc[r0] + i) begin fails++;
        $display("FAIL l3_addr[%0d]: got %0d at +%0d expected %0d at +%0d", i, rb_addr[r0+i], rb_cyc[r0+i] - rb_cyc[r0], i, i); end
      checks++; if (wb_mask[w0+i] != (1 << (i % 4))) begin fails++; $display("FAIL l3_mask[%0d]: got %0h expected %0h", i, wb_mask[w0+i], 1 << (i % 4)); end
      checks++; if (wb_data[w0+i] != int'(rom_val(i))) begin fails++; $display("FAIL l3_data[%0d]: got %0h expected %0h", i, wb_data[w0+i], rom_val(i)); end
      checks++; if (wb_cyc[w0+i] - rb_cyc[r0+i] != 4) begin fails++; $display("FAIL l3_latency[%0d]: got %0d expected 4", i, wb_cyc[w0+i] - rb_cyc[r0+i]); end
    end
    checks++; if (db_cnt - d0 != 1 || busy_b !== 1'b0) begin fails++; $display("FAIL l3_done_busy: got pulses=%0d busy=%b expected 1 and 0", db_cnt - d0, busy_b); end
  endtask

  initial begin
    test_reset();
    test_rr_basic();
    test_rr_stall();
    test_broadcast();
    test_len_zero();
    test_wrap_and_ignore();
    test_reset_midrun();
    test_latency3();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
